// File: rtl/keypad_scanner_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | keypad_scanner_if : keypad matrix lines plus accepted-key outputs  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface keypad_scanner_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  row_n,
    output col_n,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row_n,
    input  col_n,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | keypad_scanner : 4x4 matrix column scan, debounce, one code/press  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module keypad_scanner #(
  parameter int SCAN_TICKS   = 125000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  keypad_scanner_if.master  kp
);

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_ACCEPT   = 2'd2,
    S_PRESSED  = 2'd3
  } state_t;

  localparam logic [16:0] TICK_LAST  = 17'(SCAN_TICKS - 1);
  localparam logic [3:0]  DEB_TARGET = 4'(DEBOUNCE_CNT);

  state_t      state_q, state_d;
  logic [3:0]  row_meta_q, row_s_q;
  logic [16:0] tick_cnt_q;
  logic [3:0]  col_n_q, col_n_d;
  logic [1:0]  cap_row_q, cap_row_d;
  logic [1:0]  cap_col_q, cap_col_d;
  logic [3:0]  deb_cnt_q, deb_cnt_d;
  logic [3:0]  rel_cnt_q, rel_cnt_d;
  logic [3:0]  key_code_q, key_code_d;
  logic        key_valid_q, key_valid_d;
  logic        key_held_q, key_held_d;

  logic        tick_w;
  logic        any_row_w;
  logic [1:0]  row_idx_w;
  logic [1:0]  col_idx_w;
  logic        cap_low_w;
  logic [3:0]  col_rot_w;

  assign tick_w    = (tick_cnt_q == TICK_LAST);
  assign any_row_w = (row_s_q != 4'b1111);
  assign cap_low_w = ~row_s_q[cap_row_q];
  assign col_rot_w = {col_n_q[2:0], col_n_q[3]};

  always_comb begin
    row_idx_w = 2'd0;
    if (!row_s_q[0])      row_idx_w = 2'd0;
    else if (!row_s_q[1]) row_idx_w = 2'd1;
    else if (!row_s_q[2]) row_idx_w = 2'd2;
    else if (!row_s_q[3]) row_idx_w = 2'd3;
  end

  always_comb begin
    col_idx_w = 2'd0;
    case (col_n_q)
      4'b1110: col_idx_w = 2'd0;
      4'b1101: col_idx_w = 2'd1;
      4'b1011: col_idx_w = 2'd2;
      4'b0111: col_idx_w = 2'd3;
      default: col_idx_w = 2'd0;
    endcase
  end

  // Outputs are loaded on the completing tick so they appear one cycle later,
  // i.e. during the single ACCEPT cycle.
  always_comb begin
    state_d     = state_q;
    col_n_d     = col_n_q;
    cap_row_d   = cap_row_q;
    cap_col_d   = cap_col_q;
    deb_cnt_d   = deb_cnt_q;
    rel_cnt_d   = rel_cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    case (state_q)
      S_SCAN: begin
        if (tick_w) begin
          if (!any_row_w) begin
            col_n_d = col_rot_w;
          end else begin
            cap_row_d = row_idx_w;
            cap_col_d = col_idx_w;
            deb_cnt_d = 4'd1;
            if (DEBOUNCE_CNT == 1) begin
              state_d     = S_ACCEPT;
              key_code_d  = {row_idx_w, col_idx_w};
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end else begin
              state_d = S_DEBOUNCE;
            end
          end
        end
      end
      S_DEBOUNCE: begin
        if (tick_w) begin
          if (cap_low_w) begin
            deb_cnt_d = deb_cnt_q + 4'd1;
            if (deb_cnt_q + 4'd1 == DEB_TARGET) begin
              state_d     = S_ACCEPT;
              key_code_d  = {cap_row_q, cap_col_q};
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end
          end else begin
            deb_cnt_d = 4'd0;
            col_n_d   = col_rot_w;
            state_d   = S_SCAN;
          end
        end
      end
      S_ACCEPT: begin
        deb_cnt_d = 4'd0;
        rel_cnt_d = 4'd0;
        state_d   = S_PRESSED;
      end
      S_PRESSED: begin
        if (tick_w) begin
          if (!cap_low_w) begin
            rel_cnt_d = rel_cnt_q + 4'd1;
            if (rel_cnt_q + 4'd1 == DEB_TARGET) begin
              rel_cnt_d  = 4'd0;
              key_held_d = 1'b0;
              col_n_d    = col_rot_w;
              state_d    = S_SCAN;
            end
          end else begin
            rel_cnt_d = 4'd0;
          end
        end
      end
      default: state_d = S_SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta_q  <= 4'b1111;
      row_s_q     <= 4'b1111;
      tick_cnt_q  <= 17'd0;
      state_q     <= S_SCAN;
      col_n_q     <= 4'b1110;
      cap_row_q   <= 2'd0;
      cap_col_q   <= 2'd0;
      deb_cnt_q   <= 4'd0;
      rel_cnt_q   <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      row_meta_q  <= kp.row_n;
      row_s_q     <= row_meta_q;
      tick_cnt_q  <= tick_w ? 17'd0 : tick_cnt_q + 17'd1;
      state_q     <= state_d;
      col_n_q     <= col_n_d;
      cap_row_q   <= cap_row_d;
      cap_col_q   <= cap_col_d;
      deb_cnt_q   <= deb_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign kp.col_n     = col_n_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_keypad_scanner : directed bench with a 4x4 keypad matrix model  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] keys = 16'd0;

  int checks   = 0;
  int failures = 0;

  keypad_scanner_if kif ();

  keypad_scanner #(
    .SCAN_TICKS  (8),
    .DEBOUNCE_CNT(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kif.master)
  );

  always #4 clk = ~clk;

  function automatic logic [3:0] row_model(input logic [15:0] k, input logic [3:0] c);
    logic [3:0] r;
    r = 4'b1111;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (k[ri*4+ci] && !c[ci]) r[ri] = 1'b0;
    return r;
  endfunction

  assign kif.row_n = row_model(keys, kif.col_n);

  function automatic int kidx(input int r, input int c);
    return r * 4 + c;
  endfunction

  // Dwell-end reference: a tick happens on the edge where this reads 7.
  int tcnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) tcnt <= 0;
    else      tcnt <= (tcnt == 7) ? 0 : tcnt + 1;
  end

  int         valid_cnt  = 0;
  int         held_falls = 0;
  int         b2b_err    = 0;
  int         lat_err    = 0;
  logic [3:0] last_code  = 4'd0;
  logic       prev_valid = 1'b0;
  logic       prev_held  = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      if (kif.key_valid) begin
        valid_cnt <= valid_cnt + 1;
        last_code <= kif.key_code;
        if (prev_valid) b2b_err <= b2b_err + 1;
        if (tcnt != 0)  lat_err <= lat_err + 1;
      end
      if (prev_held && !kif.key_held) begin
        held_falls <= held_falls + 1;
        if (tcnt != 0) lat_err <= lat_err + 1;
      end
    end
    prev_valid <= rst & kif.key_valid;
    prev_held  <= rst & kif.key_held;
  end

  task automatic wait_held(input logic level, input int budget, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (kif.key_held === level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (kif.key_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic tick_align();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (tcnt == 0) break;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (kif.col_n !== 4'b1110) begin failures++; $display("FAIL reset_col_n got=%b exp=1110", kif.col_n); end
    checks++; if (kif.key_code !== 4'd0) begin failures++; $display("FAIL reset_key_code got=%b exp=0000", kif.key_code); end
    checks++; if (kif.key_valid !== 1'b0) begin failures++; $display("FAIL reset_key_valid got=%b exp=0", kif.key_valid); end
    checks++; if (kif.key_held !== 1'b0) begin failures++; $display("FAIL reset_key_held got=%b exp=0", kif.key_held); end
    rst = 1'b1;
  endtask

  task automatic test_steady_press();
    int base;
    int n;
    bit ok;
    base = valid_cnt;
    keys[kidx(2, 1)] = 1'b1;
    repeat (200) @(negedge clk);
    checks++; if (valid_cnt - base !== 1) begin failures++; $display("FAIL steady_pulses got=%0d exp=1", valid_cnt - base); end
    checks++; if (last_code !== 4'b1001) begin failures++; $display("FAIL steady_pulse_code got=%b exp=1001", last_code); end
    checks++; if (kif.key_code !== 4'b1001) begin failures++; $display("FAIL steady_key_code got=%b exp=1001", kif.key_code); end
    checks++; if (kif.key_held !== 1'b1) begin failures++; $display("FAIL steady_held got=%b exp=1", kif.key_held); end
    checks++; if (kif.col_n !== 4'b1101) begin failures++; $display("FAIL steady_col_frozen got=%b exp=1101", kif.col_n); end
    tick_align();
    keys[kidx(2, 1)] = 1'b0;
    wait_held(1'b0, 64, n, ok);
    checks++; if (!ok || n != 24) begin failures++; $display("FAIL release_latency got=%0d exp=24 (found=%0d)", n, ok); end
    checks++; if (kif.col_n !== 4'b1011) begin failures++; $display("FAIL release_col_resume got=%b exp=1011", kif.col_n); end
  endtask

  task automatic test_short_press();
    int base;
    base = valid_cnt;
    checks++; if (kif.col_n !== 4'b1011) begin failures++; $display("FAIL short_start_col got=%b exp=1011", kif.col_n); end
    keys[kidx(0, 2)] = 1'b1;
    repeat (8) @(negedge clk);
    keys[kidx(0, 2)] = 1'b0;
    repeat (64) @(negedge clk);
    checks++; if (valid_cnt - base !== 0) begin failures++; $display("FAIL short_no_pulse got=%0d exp=0", valid_cnt - base); end
    checks++; if (kif.key_code !== 4'b1001) begin failures++; $display("FAIL short_code_kept got=%b exp=1001", kif.key_code); end
    checks++; if (kif.key_held !== 1'b0) begin failures++; $display("FAIL short_held got=%b exp=0", kif.key_held); end
  endtask

  task automatic test_two_rows();
    int base;
    int n;
    bit ok;
    base = valid_cnt;
    keys[kidx(0, 3)] = 1'b1;
    keys[kidx(2, 3)] = 1'b1;
    wait_valid(160, ok);
    checks++; if (!ok) begin failures++; $display("FAIL two_rows_pulse got=none exp=pulse"); end
    checks++; if (kif.key_code !== 4'b0011) begin failures++; $display("FAIL two_rows_code got=%b exp=0011", kif.key_code); end
    repeat (40) @(negedge clk);
    checks++; if (valid_cnt - base !== 1) begin failures++; $display("FAIL two_rows_pulses got=%0d exp=1", valid_cnt - base); end
    keys = 16'd0;
    wait_held(1'b0, 64, n, ok);
    checks++; if (!ok) begin failures++; $display("FAIL two_rows_release got=held exp=released"); end
  endtask

  task automatic test_glitch_hold();
    int base;
    int falls;
    int n;
    bit ok;
    base = valid_cnt;
    keys[kidx(1, 0)] = 1'b1;
    wait_held(1'b1, 200, n, ok);
    checks++; if (!ok) begin failures++; $display("FAIL glitch_accept got=not_held exp=held"); end
    keys[kidx(2, 3)] = 1'b1;
    falls = held_falls;
    tick_align();
    for (int g = 0; g < 20; g++) begin
      keys[kidx(1, 0)] = 1'b0;
      repeat (8) @(negedge clk);
      keys[kidx(1, 0)] = 1'b1;
      repeat (8) @(negedge clk);
    end
    checks++; if (kif.key_held !== 1'b1) begin failures++; $display("FAIL glitch_held got=%b exp=1", kif.key_held); end
    checks++; if (held_falls - falls !== 0) begin failures++; $display("FAIL glitch_held_drops got=%0d exp=0", held_falls - falls); end
    checks++; if (valid_cnt - base !== 1) begin failures++; $display("FAIL glitch_pulses got=%0d exp=1", valid_cnt - base); end
    checks++; if (kif.key_code !== 4'b0100) begin failures++; $display("FAIL glitch_code got=%b exp=0100", kif.key_code); end
    keys = 16'd0;
    wait_held(1'b0, 64, n, ok);
    checks++; if (!ok) begin failures++; $display("FAIL glitch_release got=held exp=released"); end
  endtask

  task automatic test_reset_mid();
    int base;
    int n;
    bit ok;
    repeat (40) @(negedge clk);
    keys[kidx(3, 1)] = 1'b1;
    wait_held(1'b1, 200, n, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rstmid_accept got=not_held exp=held"); end
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (kif.col_n !== 4'b1110) begin failures++; $display("FAIL rstmid_col_n got=%b exp=1110", kif.col_n); end
    checks++; if (kif.key_held !== 1'b0) begin failures++; $display("FAIL rstmid_held got=%b exp=0", kif.key_held); end
    checks++; if (kif.key_code !== 4'd0) begin failures++; $display("FAIL rstmid_code got=%b exp=0000", kif.key_code); end
    @(negedge clk);
    rst = 1'b1;
    base = valid_cnt;
    wait_valid(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rstmid_reaccept got=none exp=pulse"); end
    checks++; if (kif.key_code !== 4'b1101) begin failures++; $display("FAIL rstmid_code_after got=%b exp=1101", kif.key_code); end
    repeat (80) @(negedge clk);
    checks++; if (valid_cnt - base !== 1) begin failures++; $display("FAIL rstmid_pulses got=%0d exp=1", valid_cnt - base); end
    keys = 16'd0;
    wait_held(1'b0, 64, n, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rstmid_release got=held exp=released"); end
  endtask

  task automatic test_back_to_back();
    repeat (2) @(negedge clk);
    checks++; if (b2b_err !== 0) begin failures++; $display("FAIL valid_back_to_back got=%0d exp=0", b2b_err); end
    checks++; if (lat_err !== 0) begin failures++; $display("FAIL edge_alignment got=%0d exp=0", lat_err); end
  endtask

  initial begin
    test_reset();
    test_steady_press();
    test_short_press();
    test_two_rows();
    test_glitch_hold();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side companion to the 4-digit seven-segment time display.
- The display drives one-hot digit strobes and emits segment data. This block works the other way: it drives one-hot column strobes and reads the row lines back from a 4x4 matrix keypad.
- Debounces each press and delivers one key code per press, with a single-cycle valid pulse, to the time-set logic.
- Runs on the same 125 MHz system clock as the display.

Parameters:
- SCAN_TICKS, 125000: clk cycles per column dwell (1 ms at 125 MHz). Legal range 4..131072.
- DEBOUNCE_CNT, 4: consecutive matching dwell-end samples required to accept a press, and again to accept a release. Legal range 1..15.

Ports:
- clk  input  1  system clock, 125 MHz.
- rst  input  1  asynchronous, active-low reset.
- row_n  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
- col_n  output  4  column strobes, active-low one-cold; exactly one bit is low at all times.
- key_code  output  4  {row_idx[1:0], col_idx[1:0]} of the accepted key. Held until the next accepted key.
- key_valid  output  1  one-clk pulse when a press is accepted.
- key_held  output  1  high from press acceptance until release acceptance.

Behaviour:
- Reset (rst=0, asynchronous): col_n=4'b1110 (col 0), key_code=0, key_valid=0, key_held=0, state=SCAN, all counters 0, synchronizer flops set to 4'b1111.
- Synchronizer: row_n passes through 2 flops to give row_s. All decisions use row_s only.
- Tick counter:
  - 17 bits, counts 0..SCAN_TICKS-1 and wraps.
  - tick = 1 on the cycle the counter equals SCAN_TICKS-1.
  - Free-running in every state.
- Row decode: row_idx is the lowest-index low bit of row_s (row 0 has the highest priority). any_row = (row_s != 4'b1111).
- State SCAN:
  - On tick with any_row=0: rotate the column, col_n <= {col_n[2:0], col_n[3]} (0->1->2->3->0).
  - On tick with any_row=1: capture cap_row=row_idx and cap_col=current column, freeze col_n, set deb_cnt=1. If DEBOUNCE_CNT=1, go to ACCEPT; otherwise go to DEBOUNCE.
- State DEBOUNCE (column frozen):
  - On tick with row_s[cap_row]=0: deb_cnt++. When deb_cnt reaches DEBOUNCE_CNT, go to ACCEPT.
  - On tick with row_s[cap_row]=1: deb_cnt=0, rotate column, go to SCAN. No outputs change.
- State ACCEPT: lasts exactly 1 cycle. key_code <= {cap_row, cap_col}, key_valid=1, key_held <= 1, rel_cnt=0, then go to PRESSED.
- State PRESSED (column frozen):
  - On tick with row_s[cap_row]=1: rel_cnt++.
  - On tick with row_s[cap_row]=0: rel_cnt=0.
  - When rel_cnt reaches DEBOUNCE_CNT: key_held <= 0, rotate column, go to SCAN.
  - Other rows pressed in the same column while in PRESSED are ignored.
- Latency:
  - key_valid and the key_held rise occur 1 cycle after the tick that completes the press count.
  - key_held falls 1 cycle after the tick that completes the release count.
- key_valid: never high for 2 consecutive cycles. Exactly one pulse per accepted press, regardless of hold duration.
- Boundaries:
  - Bounce shorter than DEBOUNCE_CNT samples produces no key_valid.
  - Bounce during a hold resets rel_cnt and produces no extra pulse.
  - Keys pressed in other columns are invisible while the column is frozen.
  - Reset mid-operation returns to the reset values immediately; a key still held is rescanned from col 0 after release of reset.

Test Plan:
(Bench parameters: SCAN_TICKS=8, DEBOUNCE_CNT=3.)
- Row 2/col 1 pressed steady for 200 clks -> exactly one key_valid pulse with key_code=4'b1001. key_held=1 until release; col_n stays at 4'b1101 while held.
- Then release row 2 -> key_held=0 one clk after the 3rd released tick. Scanning resumes at col_n=4'b1011.
- Row 0/col 2 pressed for 1 dwell only, then released -> no key_valid, key_code unchanged, scanning continues.
- Rows 0 and 2 low together on col 3 -> key_code=4'b0011, one pulse.
- Hold row 1/col 0; inject 1-tick release glitches every 2 ticks for 40 ticks -> key_held stays 1, no second key_valid.
- rst=0 asserted while in PRESSED -> col_n=4'b1110, key_held=0, key_code=0 within the same cycle, asynchronously. With the key still held after reset release, it is reaccepted exactly once.
